// File: rtl/draw_sequencer.sv
// Blit sequencer: round-robin between two drawing clients, then walks x/y/romAddr one pixel per cycle.
// Latency: grant at t, first pixel at t+1, done at t+1+W*H; all outputs registered.
// Backpressure: none downstream; requests seen while busy are not queued and are served later by RR.
module draw_sequencer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        req,
  input  logic [1:0]        reqKind,
  input  logic [9:0]        reqSel,
  input  logic [15:0]       reqX,
  input  logic [13:0]       reqY,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic              busy,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [ADDR_W-1:0] romAddr,
  output logic [4:0]        memorySel,
  output logic              plot
);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  localparam logic [8:0] SCR_W9   = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8   = 8'(SCREEN_H);
  localparam logic [7:0] SCR_W_M1 = 8'(SCREEN_W - 1);
  localparam logic [6:0] SCR_H_M1 = 7'(SCREEN_H - 1);
  localparam logic [7:0] SPR_W_M1 = 8'(SPRITE_W - 1);
  localparam logic [6:0] SPR_H_M1 = 7'(SPRITE_H - 1);

  state_t            state, state_nxt;
  logic              last_gnt;   // client granted most recently; reset value favours client 0
  logic              kind_q;
  logic [7:0]        org_x;
  logic [6:0]        org_y;
  logic [7:0]        col;
  logic [6:0]        row;
  logic [ADDR_W-1:0] addr_cnt;

  logic              any_req, win, last_px;
  logic [7:0]        w_m1;
  logic [6:0]        h_m1;
  logic [8:0]        sum_x;
  logic [7:0]        sum_y;

  logic [1:0]        grant_nxt, done_nxt;
  logic              busy_nxt, plot_nxt;
  logic [7:0]        x_nxt;
  logic [6:0]        y_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  always_comb begin
    any_req = |req;
    win     = (req == 2'b10) || ((req == 2'b11) && !last_gnt);
    w_m1    = kind_q ? SCR_W_M1 : SPR_W_M1;
    h_m1    = kind_q ? SCR_H_M1 : SPR_H_M1;
    last_px = (col == w_m1) && (row == h_m1);
    // one extra bit so origins near the edge clip instead of wrapping
    sum_x   = {1'b0, org_x} + {1'b0, col};
    sum_y   = {1'b0, org_y} + {1'b0, row};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = DRAW;
      DRAW:    if (last_px) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt = 2'b00;
    done_nxt  = 2'b00;
    busy_nxt  = 1'b0;
    plot_nxt  = 1'b0;
    x_nxt     = x;
    y_nxt     = y;
    addr_nxt  = romAddr;
    case (state)
      IDLE: begin
        if (any_req) grant_nxt = win ? 2'b10 : 2'b01;
      end
      DRAW: begin
        busy_nxt = 1'b1;
        plot_nxt = (sum_x < SCR_W9) && (sum_y < SCR_H8);
        x_nxt    = sum_x[7:0];
        y_nxt    = sum_y[6:0];
        addr_nxt = addr_cnt;
      end
      FINISH: begin
        busy_nxt = 1'b1;
        done_nxt = last_gnt ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant   <= 2'b00;
      done    <= 2'b00;
      busy    <= 1'b0;
      plot    <= 1'b0;
      x       <= '0;
      y       <= '0;
      romAddr <= '0;
    end else begin
      grant   <= grant_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
      plot    <= plot_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      romAddr <= addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_gnt  <= 1'b1;
      kind_q    <= 1'b0;
      memorySel <= '0;
      org_x     <= '0;
      org_y     <= '0;
      col       <= '0;
      row       <= '0;
      addr_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            last_gnt  <= win;
            kind_q    <= win ? reqKind[1] : reqKind[0];
            memorySel <= win ? reqSel[9:5] : reqSel[4:0];
            if (win ? reqKind[1] : reqKind[0]) begin
              org_x <= '0;
              org_y <= '0;
            end else begin
              org_x <= win ? reqX[15:8] : reqX[7:0];
              org_y <= win ? reqY[13:7] : reqY[6:0];
            end
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
          end
        end
        DRAW: begin
          // counters are parked at zero after the last pixel so romAddr stays in range
          if (last_px) begin
            col      <= '0;
            row      <= '0;
            addr_cnt <= '0;
          end else begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            if (col == w_m1) begin
              col <= '0;
              row <= row + 7'd1;
            end else begin
              col <= col + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
